// File: rtl/ppu_sched.sv
// Layer-level scheduler for the post-processing unit: hands accumulator
// tiles to the PPU, paces its busy window and quantization groups.
module ppu_sched #(
    parameter int ROW_CYCLES    = 16,
    parameter int TILES_PER_GRP = 4,
    parameter int GRP_W         = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_cfg_valid,
    output logic                             o_cfg_ready,
    input  logic [1:0]                       i_cfg_mode,
    input  logic                             i_cfg_relu_en,
    input  logic                             i_cfg_findmax,
    input  logic [GRP_W-1:0]                 i_cfg_num_grp,
    input  logic                             i_acc_valid,
    output logic                             o_acc_ready,
    output logic                             o_ppu_start,
    output logic [1:0]                       o_mode,
    output logic                             o_relu_en,
    output logic                             o_findmax,
    input  logic                             i_quant_done,
    input  logic                             i_abort,
    output logic [$clog2(TILES_PER_GRP)-1:0] o_tile_idx,
    output logic [GRP_W-1:0]                 o_grp_idx,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_err
);

    localparam int RW = $clog2(ROW_CYCLES);
    localparam int TW = $clog2(TILES_PER_GRP);

    localparam logic [RW-1:0] ROW_LAST  = RW'(ROW_CYCLES - 1);
    localparam logic [TW-1:0] TILE_LAST = TW'(TILES_PER_GRP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACC,
        S_STREAM,
        S_WAIT_Q,
        S_DONE
    } state_t;

    state_t           state;
    logic [RW-1:0]    row_cnt;
    logic [GRP_W-1:0] num_grp;
    logic             abort_pend;

    // Abort gates the same-cycle handshakes so it always wins a tie.
    assign o_cfg_ready = (state == S_IDLE) && !i_abort;
    assign o_acc_ready = (state == S_WAIT_ACC) && i_acc_valid && !i_abort;
    assign o_ppu_start = o_acc_ready;
    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE) && !i_abort;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            row_cnt    <= '0;
            num_grp    <= '0;
            abort_pend <= 1'b0;
            o_mode     <= '0;
            o_relu_en  <= 1'b0;
            o_findmax  <= 1'b0;
            o_tile_idx <= '0;
            o_grp_idx  <= '0;
            o_err      <= 1'b0;
        end else begin
            if (i_quant_done && state != S_WAIT_Q)
                o_err <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (i_cfg_valid && !i_abort) begin
                        o_mode     <= i_cfg_mode;
                        o_relu_en  <= i_cfg_relu_en;
                        o_findmax  <= i_cfg_findmax;
                        num_grp    <= i_cfg_num_grp;
                        o_tile_idx <= '0;
                        o_grp_idx  <= '0;
                        abort_pend <= 1'b0;
                        if (i_cfg_num_grp == '0)
                            state <= S_DONE;
                        else
                            state <= S_WAIT_ACC;
                    end
                end
                S_WAIT_ACC: begin
                    if (i_abort) begin
                        state <= S_IDLE;
                    end else if (i_acc_valid) begin
                        row_cnt <= '0;
                        state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    // Abort is deferred so the PPU finishes its current tile.
                    if (i_abort)
                        abort_pend <= 1'b1;
                    if (row_cnt == ROW_LAST) begin
                        if (abort_pend || i_abort) begin
                            abort_pend <= 1'b0;
                            state      <= S_IDLE;
                        end else if (o_tile_idx != TILE_LAST) begin
                            o_tile_idx <= o_tile_idx + TW'(1);
                            state      <= S_WAIT_ACC;
                        end else begin
                            o_tile_idx <= '0;
                            state      <= S_WAIT_Q;
                        end
                    end else begin
                        row_cnt <= row_cnt + RW'(1);
                    end
                end
                S_WAIT_Q: begin
                    if (i_abort) begin
                        state <= S_IDLE;
                    end else if (i_quant_done) begin
                        if (o_grp_idx == num_grp - GRP_W'(1)) begin
                            state <= S_DONE;
                        end else begin
                            o_grp_idx <= o_grp_idx + GRP_W'(1);
                            state     <= S_WAIT_ACC;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_sched.sv
// Directed bench for ppu_sched: expected tile starts go to a scoreboard
// queue and are checked as the DUT issues start pulses.
module tb_ppu_sched;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_cfg_valid;
    logic       o_cfg_ready;
    logic [1:0] i_cfg_mode;
    logic       i_cfg_relu_en;
    logic       i_cfg_findmax;
    logic [7:0] i_cfg_num_grp;
    logic       i_acc_valid;
    logic       o_acc_ready;
    logic       o_ppu_start;
    logic [1:0] o_mode;
    logic       o_relu_en;
    logic       o_findmax;
    logic       i_quant_done;
    logic       i_abort;
    logic [1:0] o_tile_idx;
    logic [7:0] o_grp_idx;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    ppu_sched dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cfg_valid  (i_cfg_valid),
        .o_cfg_ready  (o_cfg_ready),
        .i_cfg_mode   (i_cfg_mode),
        .i_cfg_relu_en(i_cfg_relu_en),
        .i_cfg_findmax(i_cfg_findmax),
        .i_cfg_num_grp(i_cfg_num_grp),
        .i_acc_valid  (i_acc_valid),
        .o_acc_ready  (o_acc_ready),
        .o_ppu_start  (o_ppu_start),
        .o_mode       (o_mode),
        .o_relu_en    (o_relu_en),
        .o_findmax    (o_findmax),
        .i_quant_done (i_quant_done),
        .i_abort      (i_abort),
        .o_tile_idx   (o_tile_idx),
        .o_grp_idx    (o_grp_idx),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [7:0] grp;
        logic [1:0] tile;
        logic [1:0] mode;
    } exp_t;

    exp_t sb[$];
    int   start_cyc[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    int   done_cnt = 0;
    int   base;
    int   dbase;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_grp(input int g, input logic [1:0] m, input int ntiles);
        exp_t e;
        for (int t = 0; t < ntiles; t++) begin
            e.grp  = 8'(g);
            e.tile = 2'(t);
            e.mode = m;
            sb.push_back(e);
        end
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k;
        k = 0;
        while (start_cnt < n && k < budget) begin
            tick();
            k++;
        end
        check("start_wait", 32'(start_cnt >= n), 32'd1);
    endtask

    task automatic drive_cfg(input logic [1:0] m, input logic r,
                             input logic f, input logic [7:0] ng);
        i_cfg_mode    = m;
        i_cfg_relu_en = r;
        i_cfg_findmax = f;
        i_cfg_num_grp = ng;
        i_cfg_valid   = 1'b1;
        tick();
        i_cfg_valid   = 1'b0;
    endtask

    function automatic logic [19:0] outvec();
        return {o_cfg_ready, o_ppu_start, o_acc_ready, o_busy, o_done, o_err,
                o_mode, o_relu_en, o_findmax, o_tile_idx, o_grp_idx};
    endfunction

    always @(posedge i_clk) cyc++;

    always @(negedge i_clk) begin
        if (!i_rst && o_done)
            done_cnt++;
        if (!i_rst && o_ppu_start) begin
            start_cnt++;
            start_cyc.push_back(cyc);
            check("acc_ready_w_start", 32'(o_acc_ready), 32'd1);
            if (sb.size() == 0) begin
                check("start_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("start_grp", 32'(o_grp_idx), 32'(e.grp));
                check("start_tile", 32'(o_tile_idx), 32'(e.tile));
                check("start_mode", 32'(o_mode), 32'(e.mode));
            end
        end
    end

    initial begin
        i_rst = 1'b1;
        i_cfg_valid = 1'b0;
        i_cfg_mode = 2'd0;
        i_cfg_relu_en = 1'b0;
        i_cfg_findmax = 1'b0;
        i_cfg_num_grp = 8'd0;
        i_acc_valid = 1'b0;
        i_quant_done = 1'b0;
        i_abort = 1'b0;
        #1;
        check("reset_outputs", 32'(outvec()), 32'h80000);
        tick();
        tick();
        i_rst = 1'b0;
        tick();

        // 1: one group, acc always valid, quant done 5 cycles into WAIT_Q
        push_grp(0, 2'd2, 4);
        i_acc_valid = 1'b1;
        base = start_cnt;
        dbase = done_cnt;
        drive_cfg(2'd2, 1'b1, 1'b0, 8'd1);
        wait_starts(base + 4, 100);
        for (int i = 1; i < 4; i++)
            check("start_spacing", 32'(start_cyc[base+i] - start_cyc[base+i-1]), 32'd17);
        repeat (16) tick();
        @(negedge i_clk);
        check("t1_waitq_no_ready", 32'(o_acc_ready), 32'd0);
        check("t1_waitq_busy", 32'(o_busy), 32'd1);
        repeat (5) tick();
        i_quant_done = 1'b1;
        tick();
        i_quant_done = 1'b0;
        @(negedge i_clk);
        check("t1_done", 32'(o_done), 32'd1);
        check("t1_mode", 32'(o_mode), 32'd2);
        check("t1_relu", 32'(o_relu_en), 32'd1);
        tick();
        @(negedge i_clk);
        check("t1_idle_ready", 32'(o_cfg_ready), 32'd1);
        check("t1_done_once", 32'(done_cnt - dbase), 32'd1);
        i_acc_valid = 1'b0;

        // 2: three groups, acc_valid arriving 10 cycles into each WAIT_ACC
        for (int g = 0; g < 3; g++)
            push_grp(g, 2'd1, 4);
        dbase = done_cnt;
        drive_cfg(2'd1, 1'b0, 1'b0, 8'd3);
        for (int g = 0; g < 3; g++) begin
            for (int t = 0; t < 4; t++) begin
                repeat (10) tick();
                i_acc_valid = 1'b1;
                base = start_cnt;
                wait_starts(base + 1, 3);
                i_acc_valid = 1'b0;
                repeat (16) tick();
            end
            repeat (3) tick();
            i_quant_done = 1'b1;
            tick();
            i_quant_done = 1'b0;
        end
        @(negedge i_clk);
        check("t2_done", 32'(o_done), 32'd1);
        check("t2_grp_last", 32'(o_grp_idx), 32'd2);
        repeat (3) tick();
        check("t2_single_done", 32'(done_cnt - dbase), 32'd1);
        check("t2_sb_drained", 32'(sb.size()), 32'd0);

        // 3: zero groups completes without starts
        base = start_cnt;
        dbase = done_cnt;
        drive_cfg(2'd1, 1'b0, 1'b1, 8'd0);
        @(negedge i_clk);
        check("t3_done", 32'(o_done), 32'd1);
        check("t3_findmax", 32'(o_findmax), 32'd1);
        tick();
        @(negedge i_clk);
        check("t3_done_pulse", 32'(o_done), 32'd0);
        check("t3_no_start", 32'(start_cnt - base), 32'd0);
        check("t3_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // abort beats config in IDLE
        i_abort = 1'b1;
        drive_cfg(2'd3, 1'b1, 1'b0, 8'd1);
        i_abort = 1'b0;
        @(negedge i_clk);
        check("idle_abort_busy", 32'(o_busy), 32'd0);
        check("idle_abort_mode", 32'(o_mode), 32'd1);

        // abort beats acc_valid in WAIT_ACC
        base = start_cnt;
        tick();
        drive_cfg(2'd0, 1'b0, 1'b0, 8'd1);
        i_abort = 1'b1;
        i_acc_valid = 1'b1;
        tick();
        i_abort = 1'b0;
        i_acc_valid = 1'b0;
        @(negedge i_clk);
        check("acc_abort_idle", 32'(o_busy), 32'd0);
        check("acc_abort_nostart", 32'(start_cnt - base), 32'd0);

        // 4: abort at row 5 of tile 1
        push_grp(0, 2'd0, 2);
        i_acc_valid = 1'b1;
        base = start_cnt;
        dbase = done_cnt;
        drive_cfg(2'd0, 1'b0, 1'b0, 8'd2);
        wait_starts(base + 2, 40);
        repeat (5) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        repeat (9) tick();
        @(negedge i_clk);
        check("t4_row15_busy", 32'(o_busy), 32'd1);
        tick();
        @(negedge i_clk);
        check("t4_idle", 32'(o_busy), 32'd0);
        check("t4_no_ready", 32'(o_acc_ready), 32'd0);
        repeat (5) tick();
        check("t4_starts", 32'(start_cnt - base), 32'd2);
        check("t4_no_done", 32'(done_cnt - dbase), 32'd0);

        // 5: stray quant_done during tile 2 sets sticky error only
        check("t5_err_clear", 32'(o_err), 32'd0);
        push_grp(0, 2'd3, 4);
        base = start_cnt;
        drive_cfg(2'd3, 1'b0, 1'b1, 8'd1);
        @(negedge i_clk);
        check("t5_mode", 32'(o_mode), 32'd3);
        wait_starts(base + 3, 60);
        repeat (3) tick();
        i_quant_done = 1'b1;
        tick();
        i_quant_done = 1'b0;
        @(negedge i_clk);
        check("t5_err", 32'(o_err), 32'd1);
        wait_starts(base + 4, 40);
        repeat (16) tick();
        repeat (8) tick();
        @(negedge i_clk);
        check("t5_waitq_busy", 32'(o_busy), 32'd1);
        check("t5_waitq_no_done", 32'(o_done), 32'd0);
        i_quant_done = 1'b1;
        tick();
        i_quant_done = 1'b0;
        @(negedge i_clk);
        check("t5_done", 32'(o_done), 32'd1);
        check("t5_err_sticky", 32'(o_err), 32'd1);
        tick();

        // 6: asynchronous reset in WAIT_Q of group 1
        push_grp(0, 2'd2, 4);
        push_grp(1, 2'd2, 4);
        base = start_cnt;
        drive_cfg(2'd2, 1'b1, 1'b1, 8'd3);
        wait_starts(base + 4, 100);
        repeat (16) tick();
        i_quant_done = 1'b1;
        tick();
        i_quant_done = 1'b0;
        wait_starts(base + 8, 100);
        repeat (16) tick();
        repeat (2) tick();
        check("t6_grp1", 32'(o_grp_idx), 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        check("t6_reset_now", 32'(outvec()), 32'h80000);
        i_acc_valid = 1'b0;
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        check("t6_cfg_ready", 32'(o_cfg_ready), 32'd1);
        check("t6_sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
